// File: rtl/serial_nibble_tx.sv
//------------------------------------------------------------------------------
// Module   : serial_nibble_tx
// Brief    : Framed MSB-first nibble transmitter (start/data/parity/stop) that
//            feeds a 4-bit serial-in shift register via ser_out/shift_en.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_nibble_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       ser_out,
  output logic       shift_en,
  output logic       busy,
  output logic       done
);

  localparam int               DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             par_q, par_d;
  logic [1:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             w_bit_end;

  assign w_bit_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
      par_q   <= 1'b0;
      bit_q   <= 2'd0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    par_d      = par_q;
    bit_d      = bit_q;
    div_d      = w_bit_end ? '0 : div_q + 1'b1;
    data_ready = 1'b0;
    busy       = 1'b1;
    ser_out    = 1'b1;
    shift_en   = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        data_ready = 1'b1;
        busy       = 1'b0;
        div_d      = '0;
        bit_d      = 2'd0;
        if (data_valid) begin
          hold_d  = data_in;
          par_d   = (^data_in) ^ PARITY_ODD;
          state_d = S_START;
        end
      end
      S_START: begin
        ser_out = 1'b0;
        if (w_bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        // bit_q counts 0..3 while the MSB is sent first
        ser_out  = hold_q[2'd3 - bit_q];
        shift_en = w_bit_end;
        if (w_bit_end) begin
          bit_d = bit_q + 2'd1;
          if (bit_q == 2'd3) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        ser_out = par_q;
        if (w_bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        done = w_bit_end;
        if (w_bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_nibble_tx
// Brief    : Self-checking bench for serial_nibble_tx with three parameter sets.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_nibble_tx;

  logic       clk;
  logic       reset;
  logic [3:0] din [3];
  logic [2:0] dv;
  wire  [2:0] rdy, ser, sh, bsy, dn;
  logic [3:0] sr [3];

  int tests;
  int fails;

  serial_nibble_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_n1_even (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .ser_out(ser[0]), .shift_en(sh[0]), .busy(bsy[0]), .done(dn[0]));

  serial_nibble_tx #(.CLKS_PER_BIT(3), .PARITY_ODD(1'b0)) u_n3_even (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .ser_out(ser[1]), .shift_en(sh[1]), .busy(bsy[1]), .done(dn[1]));

  serial_nibble_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b1)) u_n2_odd (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .ser_out(ser[2]), .shift_en(sh[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nclk(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic odd_par(input int d);
    return (d == 2);
  endfunction

  task automatic chk(input string nm, input int d, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Downstream shift register the transmitter is meant to load
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) sr[d] <= 4'd0;
    end else begin
      for (int d = 0; d < 3; d++) if (sh[d]) sr[d] <= {sr[d][2:0], ser[d]};
    end
  end

  // Reference model: pos = cycles into the current frame, -1 when idle
  int         pos [3];
  logic [6:0] mfb [3];
  logic [3:0] mnib [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) pos[d] <= -1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (pos[d] < 0) begin
          if (dv[d]) begin
            mnib[d] <= din[d];
            mfb[d]  <= {1'b0, din[d], (^din[d]) ^ odd_par(d), 1'b1};
            pos[d]  <= 0;
          end
        end else if (pos[d] == 7 * nclk(d) - 1) begin
          pos[d] <= -1;
        end else begin
          pos[d] <= pos[d] + 1;
        end
      end
    end
  end

  task automatic model_check(input int d);
    int   n;
    int   j;
    logic es, esh, edn;
    n = nclk(d);
    if (pos[d] < 0) begin
      chk("mdl_ser", d, ser[d], 1'b1);
      chk("mdl_shift", d, sh[d], 1'b0);
      chk("mdl_done", d, dn[d], 1'b0);
      chk("mdl_busy", d, bsy[d], 1'b0);
      chk("mdl_ready", d, rdy[d], 1'b1);
    end else begin
      j   = pos[d] / n;
      es  = mfb[d][6 - j];
      esh = (j >= 1) && (j <= 4) && (pos[d] % n == n - 1);
      edn = (pos[d] == 7 * n - 1);
      chk("mdl_ser", d, ser[d], es);
      chk("mdl_shift", d, sh[d], esh);
      chk("mdl_done", d, dn[d], edn);
      chk("mdl_busy", d, bsy[d], 1'b1);
      chk("mdl_ready", d, rdy[d], 1'b0);
      if (edn) chk("mdl_sreg", d, sr[d], mnib[d]);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) for (int d = 0; d < 3; d++) model_check(d);
  end

  typedef struct {
    int         d;
    logic [3:0] nib;
    logic [6:0] bits;   // start, d3, d2, d1, d0, parity, stop
    bit         pulse;
  } vec_t;

  vec_t vt [6];

  // Caller is at a falling edge with the target DUT idle
  task automatic run_vector(input int i);
    int         d;
    int         n;
    int         j;
    logic [6:0] b;
    d = vt[i].d;
    n = nclk(d);
    b = vt[i].bits;
    din[d] = vt[i].nib;
    dv[d]  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7 * n; c++) begin
      @(negedge clk);
      j = (c - 1) / n;
      chk("vec_ser", d, ser[d], b[6 - j]);
      chk("vec_shift", d, sh[d], (j >= 1) && (j <= 4) && (c % n == 0));
      chk("vec_done", d, dn[d], c == 7 * n);
      chk("vec_busy", d, bsy[d], 1'b1);
      dv[d]  = vt[i].pulse && (c == 3 * n);
      din[d] = dv[d] ? ~vt[i].nib : vt[i].nib;
    end
    @(negedge clk);
    chk("vec_ready_after", d, rdy[d], 1'b1);
    chk("vec_busy_after", d, bsy[d], 1'b0);
    chk("vec_sreg", d, sr[d], vt[i].nib);
  endtask

  task automatic chk_idle_all(input string nm);
    for (int d = 0; d < 3; d++) begin
      chk({nm, "_ser"}, d, ser[d], 1'b1);
      chk({nm, "_shift"}, d, sh[d], 1'b0);
      chk({nm, "_busy"}, d, bsy[d], 1'b0);
      chk({nm, "_done"}, d, dn[d], 1'b0);
      chk({nm, "_ready"}, d, rdy[d], 1'b1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vt[0] = '{d: 0, nib: 4'b1011, bits: 7'b0101111, pulse: 1'b0};
    vt[1] = '{d: 1, nib: 4'b0110, bits: 7'b0011001, pulse: 1'b0};
    vt[2] = '{d: 2, nib: 4'b0000, bits: 7'b0000011, pulse: 1'b0};
    vt[3] = '{d: 2, nib: 4'b0111, bits: 7'b0011101, pulse: 1'b1};
    vt[4] = '{d: 0, nib: 4'b1100, bits: 7'b0110001, pulse: 1'b1};
    vt[5] = '{d: 1, nib: 4'b1100, bits: 7'b0110001, pulse: 1'b0};

    reset = 1'b1;
    dv    = 3'b000;
    for (int d = 0; d < 3; d++) din[d] = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_all("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vector(i);

    // Abort a frame in the middle of data bit 2 on the N=3 instance
    din[1] = 4'b1010;
    dv[1]  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      dv[1] = 1'b0;
    end
    #1 reset = 1'b1;
    #1 chk_idle_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    chk_idle_all("held_rst");
    reset = 1'b0;
    run_vector(5);

    // Back-to-back frames with valid held high and data changing every cycle
    dv[0] = 1'b1;
    for (int c = 0; c < 150; c++) begin
      din[0] = 4'($urandom);
      @(negedge clk);
    end
    dv[0] = 1'b0;

    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        dv[d]  = ($urandom_range(0, 3) == 0);
        din[d] = 4'($urandom);
      end
      @(negedge clk);
    end
    dv = 3'b000;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_nibble_tx.md
# serial_nibble_tx

Framed serial transmitter that sits directly upstream of the team's 4-bit parallel/serial shift register. It accepts a 4-bit nibble over a valid/ready handshake and serialises it MSB-first inside a start/parity/stop frame. It drives the register's serial data input and its shift-select line, so after one frame the register holds the transmitted nibble. Bit timing is set by a clock-divider parameter, so the same block can also drive an off-chip line.

## Interface
- CLKS_PER_BIT, default 1: clock cycles each frame bit is held; legal range ≥1.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the idle state immediately.
- data_in  input  4  nibble to transmit; sampled only on handshake.
- data_valid  input  1  upstream has a nibble.
- data_ready  output  1  high only in IDLE; a transfer occurs on the rising edge where data_valid and data_ready are both 1.
- ser_out  output  1  serial line; drives the register's serial input; idles at 1.
- shift_en  output  1  one-cycle strobe per data bit; drives the register's shift select.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on the final cycle of STOP.

## Operation
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE:
  - ser_out=1, shift_en=0, data_ready=1, busy=0.
  - On handshake, capture data_in into the hold register, compute parity, clear the bit counter and the divider, and go to START.
- START: ser_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - ser_out = hold[3-i] for i = 0..3 (MSB first), each bit held CLKS_PER_BIT cycles.
  - shift_en=1 on the last cycle of each data-bit period only, so exactly 4 strobes per frame. Each strobe coincides with ser_out carrying that bit.
  - After i=3, go to PARITY.
- PARITY: ser_out = ^hold XOR PARITY_ODD for CLKS_PER_BIT cycles.
- STOP: ser_out=1 for CLKS_PER_BIT cycles; done=1 on the last of these cycles; then go to IDLE.
- Divider counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. With CLKS_PER_BIT=1 it is constant 0 and every cycle is a bit boundary.
- Bit index is 2 bits and wraps 3→0 when leaving DATA.
- All outputs are registered or decoded from registered state; no combinational path from data_valid to any output.
- data_valid and data_in are ignored whenever state ≠ IDLE. A nibble presented mid-frame is not lost only if upstream holds it until data_ready returns.
- Because the downstream register shifts on every shift_en strobe, the transmitted nibble sits in it after the 4th strobe.

## Timing
- Reset values: ser_out=1, shift_en=0, busy=0, done=0, data_ready=1, state=IDLE, hold=0, counters=0.
- Handshake at edge k: START begins at cycle k+1 (ser_out=0, busy=1, data_ready=0).
- Frame length is 7·CLKS_PER_BIT cycles, from cycle k+1 through k+7·CLKS_PER_BIT.
- With start bit at cycle k+1, data bit i occupies cycles k+1+(1+i)·N … k+(2+i)·N, where N = CLKS_PER_BIT. Its shift_en strobe is on cycle k+(2+i)·N.
- done pulses on cycle k+7N. IDLE resumes, with data_ready=1, on cycle k+7N+1.
- Minimum handshake spacing is 7N+1 cycles; every frame is followed by at least one idle cycle.
- Reset asserted mid-frame:
  - Outputs return to reset values asynchronously; the partial frame is abandoned.
  - No done pulse and no further shift_en.
  - The first handshake is accepted on the first rising edge after reset deasserts.

## Test plan
- CLKS_PER_BIT=1, even parity, send 4'b1011:
  - ser_out over cycles k+1..k+7 = 0,1,0,1,1,1,1.
  - shift_en high on k+2..k+5.
  - done on k+7; data_ready high again on k+8.
  - A downstream 4-bit shift register holds 4'b1011.
- CLKS_PER_BIT=3, send 4'b0110: each bit is held 3 cycles, with 21 frame cycles total. Parity bit is 0. shift_en is high on k+6, k+9, k+12, k+15 only.
- PARITY_ODD=1, send 4'b0000 and then 4'b0111: parity bit is 1 for the first frame and 0 for the second.
- data_valid held high continuously with changing data_in:
  - Frames are separated by exactly one idle cycle.
  - Each frame carries the data_in value present at its own handshake edge.
  - Values changed mid-frame have no effect.
- Assert reset during DATA bit 2:
  - ser_out=1 and busy=0 immediately; no done pulse.
  - After release, a new nibble 4'b1100 transmits correctly from its start bit.
- Edge case, data_valid pulsed while busy for one cycle only: that nibble is never transmitted and busy/done timing of the current frame is unchanged.
